// File: rtl/frame_output_streamer_pkg.sv
// Shared types and sizing helpers for the frame output streamer.
package frame_output_streamer_pkg;

  // Readout sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int DEF_WIDTH      = 64;
  localparam int DEF_HEIGHT     = 64;
  localparam int DEF_FRAME_SIZE = DEF_WIDTH * DEF_HEIGHT;

  // Tag bit layout carried alongside each pixel: {sof, eol, eof}.
  localparam int TAG_W      = 3;
  localparam int TAG_SOF    = 2;
  localparam int TAG_EOL    = 1;
  localparam int TAG_EOF    = 0;
  localparam int FIFO_DEPTH = 3;

  function automatic int frame_size(input int w, input int h);
    return w * h;
  endfunction

endpackage

// File: rtl/frame_output_streamer_fifo.sv
// Three-entry register FIFO holding a pixel plus its {sof,eol,eof} tags.
// The head entry drives the stream outputs directly, so they come straight
// from flops and only move on a pop.
module stream_fifo3
  import frame_output_streamer_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  input  logic [TAG_W-1:0]  i_tag,
  output logic [DATA_W-1:0] o_data,
  output logic [TAG_W-1:0]  o_tag,
  output logic              o_valid,
  output logic [1:0]        o_count
);

  localparam int ENTRY_W = DATA_W + TAG_W;

  logic [ENTRY_W-1:0] r_mem [0:2];
  logic [1:0]         r_count;
  logic               w_pop;
  logic               w_push;
  logic [1:0]         w_wr_idx;
  logic [ENTRY_W-1:0] w_entry;

  assign w_pop    = i_pop && (r_count != 2'd0);
  assign w_push   = i_push && ((r_count != 2'd3) || w_pop);
  // With a simultaneous pop the entries shift down first, so the new one lands one slot lower.
  assign w_wr_idx = w_pop ? (r_count - 2'd1) : r_count;
  assign w_entry  = {i_data, i_tag};

  // Storage: shift toward the head on pop, write at the tail on push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) r_mem[i] <= '0;
    end else begin
      if (w_pop) begin
        r_mem[0] <= r_mem[1];
        r_mem[1] <= r_mem[2];
      end
      if (w_push) begin
        case (w_wr_idx)
          2'd0:    r_mem[0] <= w_entry;
          2'd1:    r_mem[1] <= w_entry;
          2'd2:    r_mem[2] <= w_entry;
          default: ;
        endcase
      end
    end
  end

  // Occupancy: push and pop together leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[0][ENTRY_W-1:TAG_W];
  assign o_tag   = r_mem[0][TAG_W-1:0];
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;

endmodule

// File: rtl/frame_output_streamer.sv
// Reads a finished frame out of the result buffer in raster order and
// presents it as a tagged valid/ready pixel stream. Reads are only issued
// when the FIFO plus the outstanding read still leave room, so out_ready
// never reaches the read strobe combinationally.
module frame_output_streamer
  import frame_output_streamer_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic              busy,
  output logic              done
);

  localparam int FRAME = frame_size(WIDTH, HEIGHT);
  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(HEIGHT - 1);

  state_t             r_state;
  state_t             w_next;
  logic [ADDR_W-1:0]  r_addr;
  logic [COL_W-1:0]   r_col;
  logic [ROW_W-1:0]   r_row;
  logic               r_inflight;
  logic [TAG_W-1:0]   r_tag_q;
  logic               r_done;

  logic [1:0]         w_fifo_count;
  logic [2:0]         w_occupancy;
  logic               w_issue;
  logic               w_last_issue;
  logic               w_pop;
  logic               w_eof_accept;
  logic [TAG_W-1:0]   w_tag;
  logic [TAG_W-1:0]   w_head_tag;

  assign w_occupancy  = {1'b0, w_fifo_count} + {2'b00, r_inflight};
  assign w_issue      = (r_state == ST_READ) && (w_occupancy < 3'(FIFO_DEPTH));
  assign w_last_issue = w_issue && (r_addr == LAST_ADDR);
  assign w_pop        = out_valid && out_ready;
  assign w_eof_accept = w_pop && out_eof;

  assign w_tag[TAG_SOF] = (r_col == '0) && (r_row == '0);
  assign w_tag[TAG_EOL] = (r_col == LAST_COL);
  assign w_tag[TAG_EOF] = (r_col == LAST_COL) && (r_row == LAST_ROW);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: DRAIN ends when the EOF beat leaves the last FIFO slot with nothing in flight.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_READ;
      ST_READ:  if (w_last_issue) w_next = ST_DRAIN;
      ST_DRAIN: if (!r_inflight && (w_fifo_count == 2'd1) && w_eof_accept) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Raster address with col/row kept alongside so tags need no divider; holds at the last pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_col  <= '0;
      r_row  <= '0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_addr <= '0;
      r_col  <= '0;
      r_row  <= '0;
    end else if (w_issue && !w_last_issue) begin
      r_addr <= r_addr + ADDR_W'(1);
      if (r_col == LAST_COL) begin
        r_col <= '0;
        r_row <= r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // Outstanding-read flag and the tags that travel with the returning data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_tag_q    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_tag_q <= w_tag;
    end
  end

  // One-cycle completion pulse coinciding with the return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_done <= 1'b0;
    else        r_done <= (r_state == ST_DRAIN) && (w_next == ST_IDLE);
  end

  stream_fifo3 #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_data  (mem_rd_data),
    .i_tag   (r_tag_q),
    .o_data  (out_data),
    .o_tag   (w_head_tag),
    .o_valid (out_valid),
    .o_count (w_fifo_count)
  );

  assign mem_rd_en   = w_issue;
  assign mem_rd_addr = r_addr;
  assign out_sof     = w_head_tag[TAG_SOF];
  assign out_eol     = w_head_tag[TAG_EOL];
  assign out_eof     = w_head_tag[TAG_EOF];
  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;

endmodule
